// File: rtl/polilock_pkg.sv
// Shared definitions for the Polilock password receiver: FSM state codes
// and default timing/size parameters.
package polilock_pkg;

    // State codes as seen on db_estado
    typedef enum logic [3:0] {
        OCIOSO = 4'd0,
        START  = 4'd1,
        DADOS  = 4'd2,
        PARADA = 4'd3,
        ESPERA = 4'd4,
        GRAVA  = 4'd5,
        PRONTA = 4'd6
    } estado_t;

    // 50 MHz / 9600 baud
    localparam int unsigned CLKS_PER_BIT_PADRAO = 5208;
    localparam int unsigned N_CARACTERES_PADRAO = 10;

endpackage

// File: rtl/receptor_senha_if.sv
// Signal bundle between the password receiver and its environment:
// serial input, clear, buffer read port and status/debug outputs.
interface receptor_senha_if;

    logic       rx;
    logic       limpa;
    logic [3:0] endereco_leitura;
    logic [7:0] dado_leitura;
    logic       senha_pronta;
    logic [3:0] num_caracteres;
    logic       erro_quadro;
    logic [3:0] db_estado;
    logic [7:0] db_dado;

    // Environment side: drives the line, the clear and the read address
    modport master (
        output rx,
        output limpa,
        output endereco_leitura,
        input  dado_leitura,
        input  senha_pronta,
        input  num_caracteres,
        input  erro_quadro,
        input  db_estado,
        input  db_dado
    );

    // Receiver side
    modport slave (
        input  rx,
        input  limpa,
        input  endereco_leitura,
        output dado_leitura,
        output senha_pronta,
        output num_caracteres,
        output erro_quadro,
        output db_estado,
        output db_dado
    );

endinterface

// File: rtl/uart_rx_8n1.sv
// UART 8N1 receiver: 2-flop rx synchroniser, bit timer and the
// START/DADOS/PARADA/ESPERA sequencing. Emits the received byte with a
// one-cycle valid (combinational, in the last PARADA cycle) and a
// registered one-cycle stop-bit error pulse.
module uart_rx_8n1
    import polilock_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_i,
    input  logic       limpa_i,
    input  logic       segura_i,   // hold in OCIOSO (owner is storing a byte)
    output logic [7:0] dado_o,
    output logic       valido_o,
    output logic       erro_o,
    output estado_t    estado_o
);

    localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] FIM_BIT  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] MEIO_BIT = TW'(CLKS_PER_BIT / 2 - 1);

    logic          rx_meta_q;
    logic          rx_sinc_q;
    estado_t       estado_q, estado_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          erro_q, erro_d;

    // Two-flop synchroniser, idles high
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sinc_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sinc_q <= rx_meta_q;
        end
    end

    // Receiver state, timer, bit counter, shift register and error flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= OCIOSO;
            timer_q  <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            erro_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            timer_q  <= timer_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            erro_q   <= erro_d;
        end
    end

    // Next-state logic: mid-bit sampling driven by the bit timer
    always_comb begin
        estado_d = estado_q;
        timer_d  = timer_q + TW'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        erro_d   = 1'b0;
        valido_o = 1'b0;

        case (estado_q)
            OCIOSO: begin
                timer_d = '0;
                if (!segura_i && !rx_sinc_q) begin
                    estado_d = START;
                end
            end
            START: begin
                if (timer_q == MEIO_BIT) begin
                    timer_d = '0;
                    bit_d   = '0;
                    estado_d = rx_sinc_q ? OCIOSO : DADOS;
                end
            end
            DADOS: begin
                if (timer_q == FIM_BIT) begin
                    timer_d = '0;
                    shift_d = {rx_sinc_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        estado_d = PARADA;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            PARADA: begin
                if (timer_q == FIM_BIT) begin
                    timer_d = '0;
                    if (rx_sinc_q) begin
                        valido_o = 1'b1;
                        estado_d = OCIOSO;
                    end else begin
                        erro_d   = 1'b1;
                        estado_d = ESPERA;
                    end
                end
            end
            ESPERA: begin
                timer_d = '0;
                if (rx_sinc_q) begin
                    estado_d = OCIOSO;
                end
            end
            default: begin
                timer_d  = '0;
                estado_d = OCIOSO;
            end
        endcase

        if (limpa_i) begin
            estado_d = OCIOSO;
            timer_d  = '0;
            erro_d   = 1'b0;
            valido_o = 1'b0;
        end
    end

    assign dado_o   = shift_q;
    assign erro_o   = erro_q;
    assign estado_o = estado_q;

endmodule

// File: rtl/receptor_senha.sv
// Password receiver: collects N_CARACTERES UART characters into a 16x8
// register buffer with a registered read port for the verification path.
module receptor_senha
    import polilock_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_PADRAO,
    parameter int unsigned N_CARACTERES = N_CARACTERES_PADRAO
) (
    input logic        clock,
    input logic        reset,
    receptor_senha_if.slave bus
);

    localparam logic [4:0] N_MAX = 5'(N_CARACTERES);

    logic [7:0] rx_dado;
    logic       rx_valido;
    logic       rx_erro;
    estado_t    rx_estado;

    estado_t    ctrl_q, ctrl_d;
    // One bit wider than the port so that N_CARACTERES=16 is representable;
    // at 16 the port reads 0 and senha_pronta carries the full condition.
    logic [4:0] cont_q, cont_d;
    logic       pronta_q, pronta_d;
    logic       grava_en;
    logic [7:0] mem_q [16];
    logic [7:0] leitura_q;
    logic [7:0] db_dado_q;
    estado_t    estado_vis;

    uart_rx_8n1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clock    (clock),
        .reset    (reset),
        .rx_i     (bus.rx),
        .limpa_i  (bus.limpa),
        .segura_i (ctrl_q == GRAVA),
        .dado_o   (rx_dado),
        .valido_o (rx_valido),
        .erro_o   (rx_erro),
        .estado_o (rx_estado)
    );

    // Control state, write pointer and ready flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctrl_q   <= OCIOSO;
            cont_q   <= '0;
            pronta_q <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            cont_q   <= cont_d;
            pronta_q <= pronta_d;
        end
    end

    // GRAVA stores one byte per valid frame; once full, frames are dropped
    always_comb begin
        ctrl_d   = ctrl_q;
        cont_d   = cont_q;
        pronta_d = pronta_q;
        grava_en = 1'b0;

        case (ctrl_q)
            GRAVA: begin
                if (cont_q < N_MAX) begin
                    grava_en = 1'b1;
                    cont_d   = cont_q + 5'd1;
                    if (cont_q + 5'd1 == N_MAX) begin
                        pronta_d = 1'b1;
                        ctrl_d   = PRONTA;
                    end else begin
                        ctrl_d = OCIOSO;
                    end
                end else begin
                    ctrl_d = PRONTA;
                end
            end
            PRONTA: begin
                if (rx_valido) begin
                    ctrl_d = GRAVA;
                end
            end
            default: begin
                if (rx_valido) begin
                    ctrl_d = GRAVA;
                end
            end
        endcase

        if (bus.limpa) begin
            ctrl_d   = OCIOSO;
            cont_d   = '0;
            pronta_d = 1'b0;
            grava_en = 1'b0;
        end
    end

    // Character buffer, read port (old data on same-address write) and debug byte
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 16; i++) begin
                mem_q[i] <= '0;
            end
            leitura_q <= '0;
            db_dado_q <= '0;
        end else begin
            leitura_q <= mem_q[bus.endereco_leitura];
            if (grava_en) begin
                mem_q[cont_q[3:0]] <= rx_dado;
                db_dado_q          <= rx_dado;
            end
        end
    end

    // Visible state: GRAVA, else the receiver while a frame is active, else idle/ready
    always_comb begin
        estado_vis = ctrl_q;
        if (ctrl_q != GRAVA && rx_estado != OCIOSO) begin
            estado_vis = rx_estado;
        end
    end

    assign bus.dado_leitura   = leitura_q;
    assign bus.senha_pronta   = pronta_q;
    assign bus.num_caracteres = cont_q[3:0];
    assign bus.erro_quadro    = rx_erro;
    assign bus.db_estado      = estado_vis;
    assign bus.db_dado        = db_dado_q;

endmodule

// File: doc/receptor_senha.md
Name: receptor_senha

Overview:
Upstream stage of the Polilock data path. Receives the typed password as UART 8N1 characters on a serial line and stores them in a 16x8 character buffer. It flags when a full password (N_CARACTERES characters) is available. The downstream verification data path reads the buffer through a synchronous read port addressed by its own 4-bit sequence counter and compares each character against the stored password memory.

Parameters:
CLKS_PER_BIT, 5208, clock cycles per UART bit (50 MHz / 9600 baud); must be at least 4.
N_CARACTERES, 10, characters per password (1..16); buffer addresses 0..N_CARACTERES-1.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
rx  in  1  UART serial input, idle high
limpa  in  1  synchronous clear: empties the buffer pointer, drops senha_pronta, aborts any frame in progress
endereco_leitura  in  4  buffer read address, driven by the downstream sequence counter
dado_leitura  out  8  buffer content at endereco_leitura, registered (1-cycle latency)
senha_pronta  out  1  high while N_CARACTERES characters are stored
num_caracteres  out  4  characters stored so far
erro_quadro  out  1  one-cycle pulse on a stop-bit error
db_estado  out  4  current FSM state code
db_dado  out  8  last correctly received byte

Behaviour:
- Reset values: dado_leitura=0, senha_pronta=0, num_caracteres=0, erro_quadro=0, db_estado=OCIOSO (0), db_dado=0, buffer=all 0x00, rx synchroniser=1.
- rx passes through a 2-flop synchroniser. All references to rx below mean the synchronised signal.
- Bit timer counts 0..CLKS_PER_BIT-1. Bit counter counts 0..7.
- OCIOSO (0): if rx=0, go to START and clear the timer.
- START (1): at timer=CLKS_PER_BIT/2-1, sample rx. If rx=0, go to DADOS with the timer cleared. If rx=1, treat it as a glitch and return to OCIOSO with no error.
- DADOS (2): every CLKS_PER_BIT cycles, sample one data bit (mid-bit), LSB first, into a shift register. After bit 7, go to PARADA.
- PARADA (3): after CLKS_PER_BIT cycles, sample rx.
  - rx=1: go to GRAVA.
  - rx=0: pulse erro_quadro for 1 cycle, discard the byte, go to ESPERA.
- ESPERA (4): wait for rx=1, then go to OCIOSO.
- GRAVA (5): lasts exactly 1 cycle.
  - If num_caracteres < N_CARACTERES: write the byte to buffer[num_caracteres], increment num_caracteres, update db_dado.
  - If the increment reaches N_CARACTERES, set senha_pronta in the same cycle and go to PRONTA. Otherwise go to OCIOSO.
- PRONTA (6): senha_pronta held at 1.
  - Further frames are still received and checked (erro_quadro is still reported), but they are discarded: no write, num_caracteres unchanged.
  - The FSM returns to PRONTA after each such frame.
- limpa=1 (any state, takes priority over all transitions): next cycle num_caracteres=0, senha_pronta=0, state=OCIOSO. Buffer contents are not erased; stale data stays readable.
- Read port: dado_leitura <= buffer[endereco_leitura] on every rising edge, independent of the FSM.
  - A read and a write to the same address in the same cycle returns the old data.
  - Addresses >= N_CARACTERES return stale or zero contents; no error is raised.
- num_caracteres never exceeds N_CARACTERES and never wraps.
- Asynchronous reset mid-frame: everything clears immediately and the partial byte is lost. After release, if rx is still low, the FSM enters START and the glitch check applies.

Decomposition:
- Shared package polilock_pkg: FSM state codes (OCIOSO..PRONTA, 4-bit), CLKS_PER_BIT default, N_CARACTERES default.
- One sub-module, uart_rx_8n1: synchroniser, bit timer, START/DADOS/PARADA/ESPERA logic. Outputs a byte plus a one-cycle valid and a one-cycle erro pulse.
- receptor_senha keeps the GRAVA/PRONTA control, the write pointer, the 16x8 register buffer and the read port.

Test Plan:
- CLKS_PER_BIT=16: send "0123456789" (0x30..0x39) -> num_caracteres increments 1..10; senha_pronta rises in the GRAVA cycle of the 10th byte; reads of addresses 0..9 return 0x30..0x39 one cycle after the address is applied.
- Send 0x41 with stop bit=0 -> erro_quadro high exactly 1 cycle; num_caracteres unchanged; FSM in ESPERA until rx returns high.
- rx low pulse of 4 cycles while in OCIOSO -> FSM returns to OCIOSO from START; no write, no erro_quadro.
- After 10 bytes, send an 11th byte 0x5A -> buffer[0..9] unchanged; num_caracteres=10; senha_pronta stays 1.
- Assert limpa during DADOS of the 3rd byte -> next cycle num_caracteres=0, senha_pronta=0, state OCIOSO. Then send "AB" -> addresses 0,1 = 0x41,0x42 and address 2 keeps its old content.
- Assert reset during the 5th byte -> all outputs at reset values, buffer reads 0x00 at every address. A full new password is then received correctly.
